// File: rtl/fft_bank_mux_pkg.sv
// Shared definitions for the FFT bank write multiplexer: bank state encoding,
// error-bit positions and the bank-index width helper.
package fft_bank_mux_pkg;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

    localparam int unsigned FFT_SIZE_DEF = 4096;
    localparam int unsigned ADDR_WIDTH   = $clog2(FFT_SIZE_DEF);

    localparam int unsigned ERR_DROP = 0;
    localparam int unsigned ERR_COLL = 1;
    localparam int unsigned ERR_HSK  = 2;

    function automatic int unsigned bank_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_bank_tracker.sv
// Bank ownership tracker: FREE/FULL state per bank, producer/consumer ring
// pointers, FULL-bank count and the sticky done/release handshake error.
module fft_bank_tracker
    import fft_bank_mux_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 2,
    localparam int unsigned BANK_W    = bank_w(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_done,
    input  logic              frame_release,
    output logic              wr_valid,
    output logic [BANK_W-1:0] wr_ptr,
    output logic              rd_valid,
    output logic [BANK_W-1:0] rd_ptr,
    output logic [BANK_W:0]   full_count,
    output logic              hsk_err
);

    bank_state_e       state_q [NUM_BANKS];
    bank_state_e       state_d [NUM_BANKS];
    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [BANK_W:0]   full_count_q, full_count_d;
    logic              hsk_err_q, hsk_err_d;
    logic              done_ok, rel_ok;

    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_valid = (state_q[wr_ptr_q] == BANK_FREE);
        rd_valid = (state_q[rd_ptr_q] == BANK_FULL);
        done_ok  = frame_done && wr_valid;
        rel_ok   = frame_release && rd_valid;

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        full_count_d = full_count_q;
        hsk_err_d    = hsk_err_q | (frame_done & ~done_ok) | (frame_release & ~rel_ok);

        // Both legal only when the pointers differ, so the two writes never alias.
        if (done_ok) begin
            state_d[wr_ptr_q] = BANK_FULL;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (rel_ok) begin
            state_d[rd_ptr_q] = BANK_FREE;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end

        case ({done_ok, rel_ok})
            2'b10:   full_count_d = full_count_q + 1'b1;
            2'b01:   full_count_d = full_count_q - 1'b1;
            default: full_count_d = full_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) state_q[i] <= BANK_FREE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            full_count_q <= '0;
            hsk_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_count_q <= full_count_d;
            hsk_err_q    <= hsk_err_d;
        end
    end

    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;
    assign full_count = full_count_q;
    assign hsk_err    = hsk_err_q;

endmodule

// File: rtl/fft_bank_mux.sv
// N-bank write multiplexer between the FFT a/b write ports and per-bank frame
// RAMs; registers the write path and steers enables to the bank being filled.
module fft_bank_mux
    import fft_bank_mux_pkg::*;
#(
    parameter  int unsigned FFT_SIZE   = 4096,
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned NUM_BANKS  = 2,
    localparam int unsigned ADDR_WIDTH = $clog2(FFT_SIZE),
    localparam int unsigned BANK_W     = bank_w(NUM_BANKS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH-1:0]           fft_waddra,
    input  logic [ADDR_WIDTH-1:0]           fft_waddrb,
    input  logic [DATA_WIDTH-1:0]           fft_wdataa,
    input  logic [DATA_WIDTH-1:0]           fft_wdatab,
    input  logic                            fft_wea,
    input  logic                            fft_web,
    input  logic                            fft_frame_done,
    output logic                            wr_bank_valid,
    output logic [BANK_W-1:0]               wmem_id,
    output logic                            rd_frame_valid,
    output logic [BANK_W-1:0]               rd_bank_id,
    input  logic                            rd_frame_release,
    output logic [BANK_W:0]                 full_count,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] mem_addra,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] mem_addrb,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wdataa,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wdatab,
    output logic [NUM_BANKS-1:0]            mem_wea,
    output logic [NUM_BANKS-1:0]            mem_web,
    output logic [2:0]                      err_flags
);

    logic                  wr_valid;
    logic [BANK_W-1:0]     wr_ptr;
    logic                  hsk_err;
    logic                  coll;

    logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0] dataa_q, dataa_d, datab_q, datab_d;
    logic [NUM_BANKS-1:0]  wea_q, wea_d, web_q, web_d;
    logic                  drop_err_q, drop_err_d;
    logic                  coll_err_q, coll_err_d;

    fft_bank_tracker #(
        .NUM_BANKS(NUM_BANKS)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_done   (fft_frame_done),
        .frame_release(rd_frame_release),
        .wr_valid     (wr_valid),
        .wr_ptr       (wr_ptr),
        .rd_valid     (rd_frame_valid),
        .rd_ptr       (rd_bank_id),
        .full_count   (full_count),
        .hsk_err      (hsk_err)
    );

    always_comb begin
        coll       = fft_wea && fft_web && (fft_waddra == fft_waddrb);
        addra_d    = fft_waddra;
        addrb_d    = fft_waddrb;
        dataa_d    = fft_wdataa;
        datab_d    = fft_wdatab;
        wea_d      = '0;
        web_d      = '0;
        // Writes in the done cycle use the pre-advance wr_ptr, i.e. the old bank.
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (wr_valid && (wr_ptr == BANK_W'(i))) begin
                wea_d[i] = fft_wea;
                web_d[i] = fft_web && !coll;
            end
        end
        drop_err_d = drop_err_q | ((fft_wea | fft_web) & ~wr_valid);
        coll_err_d = coll_err_q | coll;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addra_q    <= '0;
            addrb_q    <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
            wea_q      <= '0;
            web_q      <= '0;
            drop_err_q <= 1'b0;
            coll_err_q <= 1'b0;
        end else begin
            addra_q    <= addra_d;
            addrb_q    <= addrb_d;
            dataa_q    <= dataa_d;
            datab_q    <= datab_d;
            wea_q      <= wea_d;
            web_q      <= web_d;
            drop_err_q <= drop_err_d;
            coll_err_q <= coll_err_d;
        end
    end

    always_comb begin
        err_flags           = '0;
        err_flags[ERR_DROP] = drop_err_q;
        err_flags[ERR_COLL] = coll_err_q;
        err_flags[ERR_HSK]  = hsk_err;
    end

    assign wr_bank_valid = wr_valid;
    assign wmem_id       = wr_ptr;
    assign mem_addra     = {NUM_BANKS{addra_q}};
    assign mem_addrb     = {NUM_BANKS{addrb_q}};
    assign mem_wdataa    = {NUM_BANKS{dataa_q}};
    assign mem_wdatab    = {NUM_BANKS{datab_q}};
    assign mem_wea       = wea_q;
    assign mem_web       = web_q;

endmodule

// File: doc/fft_bank_mux.md
Name: fft_bank_mux

Overview:
- Generalised N-bank write multiplexer between the FFT core's dual write ports (a/b) and a set of ping-pong/round-robin frame memories.
- Tracks bank ownership: the FFT producer fills one bank while a downstream reader drains completed banks, with a frame-done/release handshake.
- Sits between the FFT datapath and the per-bank dual-port RAMs.
- Replaces the fixed two-bank, single wmem_id selection scheme.

Parameters:
- FFT_SIZE, 4096, points per frame; bank depth.
- DATA_WIDTH, 64, complex sample width per port.
- NUM_BANKS, 2, number of frame banks (legal 2..4).
- ADDR_WIDTH, $clog2(FFT_SIZE), derived localparam; matches `ADDR_WIDTH in fft_defs.vh.
- BANK_W, max(1,$clog2(NUM_BANKS)), derived localparam.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- fft_waddra  in  ADDR_WIDTH  FFT port-a write address
- fft_waddrb  in  ADDR_WIDTH  FFT port-b write address
- fft_wdataa  in  DATA_WIDTH  port-a write data
- fft_wdatab  in  DATA_WIDTH  port-b write data
- fft_wea  in  1  port-a write enable
- fft_web  in  1  port-b write enable
- fft_frame_done  in  1  single-cycle pulse: current bank complete
- wr_bank_valid  out  1  a FREE bank is granted to the FFT
- wmem_id  out  BANK_W  index of the bank being filled (wr_ptr)
- rd_frame_valid  out  1  bank at rd_ptr is FULL and readable
- rd_bank_id  out  BANK_W  bank the reader owns (rd_ptr)
- rd_frame_release  in  1  single-cycle pulse: reader finished rd_bank_id
- full_count  out  BANK_W+1  number of FULL banks
- mem_addra  out  NUM_BANKS*ADDR_WIDTH  per-bank port-a address
- mem_addrb  out  NUM_BANKS*ADDR_WIDTH  per-bank port-b address
- mem_wdataa  out  NUM_BANKS*DATA_WIDTH  per-bank port-a data
- mem_wdatab  out  NUM_BANKS*DATA_WIDTH  per-bank port-b data
- mem_wea  out  NUM_BANKS  per-bank port-a write enable
- mem_web  out  NUM_BANKS  per-bank port-b write enable
- err_flags  out  3  sticky errors: [0] write dropped, [1] a/b address collision, [2] bad done/release

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Per-bank state, 1 bit each: FREE or FULL. Pointers wr_ptr and rd_ptr wrap modulo NUM_BANKS.
- Reset values:
  - All banks FREE; wr_ptr = rd_ptr = 0.
  - All mem_* outputs 0; err_flags 0; full_count 0.
  - Consequently wr_bank_valid = 1, rd_frame_valid = 0, wmem_id = 0, rd_bank_id = 0.
- wr_bank_valid = (state[wr_ptr] == FREE). rd_frame_valid = (state[rd_ptr] == FULL). Both decode registered state only; there are no combinational paths from inputs.
- Write path, 1-cycle registered latency:
  - Port-a input at cycle t appears on bank wr_ptr(t) at t+1. Port b likewise.
  - Enables of all other banks are 0. Addresses and data fan out to every bank; only enables are steered.
- Dropped write: fft_wea or fft_web asserted while wr_bank_valid = 0 -> no mem enable; set err_flags[0].
- Address collision: fft_wea && fft_web && fft_waddra == fft_waddrb -> port a written, port b suppressed; set err_flags[1].
- fft_frame_done with wr_bank_valid = 1 -> state[wr_ptr] <= FULL and wr_ptr++ at the next edge.
  - Writes presented in the done cycle still target the old bank.
- fft_frame_done with wr_bank_valid = 0 -> ignored; set err_flags[2].
- rd_frame_release with rd_frame_valid = 1 -> state[rd_ptr] <= FREE and rd_ptr++.
- rd_frame_release with rd_frame_valid = 0 -> ignored; set err_flags[2].
- Simultaneous done and release in the same cycle: both applied.
  - They always address different banks, except when wr_ptr == rd_ptr. In that case the bank cannot be both FREE and FULL, so at most one of the two is legal.
  - A bank freed by release becomes visible to wr_bank_valid on the following cycle only.
- All banks FULL: wr_bank_valid = 0 and the FFT must stall. full_count = NUM_BANKS.
- full_count updates on the edge after done/release; when both occur in one cycle it is unchanged.
- Reset mid-frame: all in-flight writes are discarded, and every bank returns to FREE immediately (asynchronous).
- err_flags clear only on reset.

Decomposition:
- fft_defs.vh / shared package holds:
  - ADDR_WIDTH;
  - bank_state_e {BANK_FREE, BANK_FULL};
  - err bit index constants ERR_DROP = 0, ERR_COLL = 1, ERR_HSK = 2.
- One sub-module: fft_bank_tracker. It holds per-bank state, wr_ptr, rd_ptr, full_count and the handshake error logic.
- The top level holds the registered write steering and collision check.
- The verification interface extends mem_mux_if_t with the new ports.

Test Plan:
- Reset, then 4096 port-a/b writes to bank 0, then done -> mem_wea[0] asserted 1 cycle after each write; wmem_id = 1; rd_frame_valid = 1, rd_bank_id = 0, full_count = 1.
- NUM_BANKS = 3: three done pulses with no release -> wr_bank_valid = 0, full_count = 3. A write at addr 0x10 -> no mem enable; err_flags = 3'b001.
- Release then done in the same cycle (NUM_BANKS = 2, bank0 FULL, filling bank1) -> bank0 FREE, bank1 FULL, rd_bank_id = 1, wmem_id = 0, full_count stays 1.
- fft_wea = fft_web = 1, both addresses 0x123, data A/B -> bank written with A on port a, mem_web = 0; err_flags[1] = 1.
- Release with rd_frame_valid = 0 right after reset -> no state change; err_flags = 3'b100.
- rst_n asserted low mid-frame after 100 writes -> all mem_* outputs 0 immediately; after deassert wmem_id = 0, wr_bank_valid = 1, full_count = 0.
